// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and default widths for the SPI master
package spi_pkg;
    localparam int SPI_DATA_W = 8;
    localparam int SPI_DIV_W  = 8;
    typedef enum logic [1:0] {IDLE, XFER, HOLD} spi_state_e;
endpackage

// File: rtl/spi_shift_ctrl_if.sv
// spi_shift_ctrl_if: host-side request/response bundle of the SPI transaction engine
interface spi_shift_ctrl_if
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W,
    parameter int DIV_W  = SPI_DIV_W
);
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic [DIV_W-1:0]  div_val;
    logic [DATA_W-1:0] rx_data;
    logic              busy;
    logic              done;
    modport master(output start, tx_data, div_val, input rx_data, busy, done);
    modport slave(input start, tx_data, div_val, output rx_data, busy, done);
endinterface

// File: rtl/spi_edge_det.sv
// spi_edge_det: registers the divided wave and flags its rising and falling edges
module spi_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise,
    output logic fall,
    output logic level
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) level <= 1'b0;
        else level <= sig;
    assign rise = sig & ~level;
    assign fall = ~sig & level;
endmodule

// File: rtl/spi_shift_ctrl.sv
// spi_shift_ctrl: mode-0 MSB-first SPI transaction engine driven by an external clock divider
module spi_shift_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W,
    parameter int DIV_W  = SPI_DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_shift_ctrl_if.slave  host,
    output logic             div_en,
    output logic [DIV_W-1:0] div_cfg,
    input  logic             sclk_div,
    output logic             spi_sclk,
    output logic             spi_mosi,
    input  logic             spi_miso,
    output logic             spi_cs_n
);
    localparam int CNT_W = $clog2(DATA_W) + 1;
    spi_state_e        state;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DIV_W:0]    hold_cnt;
    logic              rise, fall, sclk_q;
    spi_edge_det edge_det (
        .clk  (clk),
        .rst_n(rst_n),
        .sig  (sclk_div),
        .rise (rise),
        .fall (fall),
        .level(sclk_q)
    );
    assign spi_sclk = sclk_q & (state == XFER);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tx_sh        <= '0;
            rx_sh        <= '0;
            bit_cnt      <= '0;
            hold_cnt     <= '0;
            div_en       <= 1'b0;
            div_cfg      <= '0;
            spi_mosi     <= 1'b0;
            spi_cs_n     <= 1'b1;
            host.rx_data <= '0;
            host.busy    <= 1'b0;
            host.done    <= 1'b0;
        end else begin
            host.done <= 1'b0;
            case (state)
                IDLE: if (host.start) begin
                    tx_sh     <= host.tx_data;
                    div_cfg   <= host.div_val;
                    bit_cnt   <= '0;
                    spi_cs_n  <= 1'b0;
                    spi_mosi  <= host.tx_data[DATA_W-1];
                    div_en    <= 1'b1;
                    host.busy <= 1'b1;
                    state     <= XFER;
                end
                XFER: begin
                    if (rise) begin
                        rx_sh   <= {rx_sh[DATA_W-2:0], spi_miso};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                    // the fall after the last rise ends the data phase; CS is held one more half-period
                    if (fall && bit_cnt == CNT_W'(DATA_W)) begin
                        div_en   <= 1'b0;
                        hold_cnt <= '0;
                        state    <= HOLD;
                    end else if (fall) begin
                        tx_sh    <= tx_sh << 1;
                        spi_mosi <= tx_sh[DATA_W-2];
                    end
                end
                HOLD: if (hold_cnt == {1'b0, div_cfg}) begin
                    spi_cs_n     <= 1'b1;
                    spi_mosi     <= 1'b0;
                    host.busy    <= 1'b0;
                    host.rx_data <= rx_sh;
                    host.done    <= 1'b1;
                    state        <= IDLE;
                end else begin
                    hold_cnt <= hold_cnt + (DIV_W+1)'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_shift_ctrl.sv
// tb_spi_shift_ctrl: directed checks of the SPI engine against a behavioural clock divider
module tb_spi_shift_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       div_en, sclk_div, spi_sclk, spi_mosi, spi_miso, spi_cs_n;
    logic [7:0] div_cfg, dcnt;
    logic       loop = 1'b1, miso_val = 1'b0, prev_sclk;
    int         cyc = 0, nchk = 0, nerr = 0;
    int         rises, dones, busy_n, cs_hi, max_dones, done_edge, first_rise, last_rise, last_fall, hold1;
    logic       mosi_hi;
    spi_shift_ctrl_if #(.DATA_W(8), .DIV_W(8)) host ();
    spi_shift_ctrl #(.DATA_W(8), .DIV_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .host    (host),
        .div_en  (div_en),
        .div_cfg (div_cfg),
        .sclk_div(sclk_div),
        .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .spi_cs_n(spi_cs_n)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;
    assign spi_miso = loop ? spi_mosi : miso_val;
    // divider: starts low once enabled and toggles every div_cfg+1 cycles
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n || !div_en) begin
            dcnt     <= '0;
            sclk_div <= 1'b0;
        end else if (dcnt == div_cfg) begin
            dcnt     <= '0;
            sclk_div <= ~sclk_div;
        end else begin
            dcnt <= dcnt + 8'd1;
        end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task automatic clr(input int md);
        rises = 0; dones = 0; busy_n = 0; cs_hi = 0; max_dones = md; done_edge = -1;
        first_rise = -1; last_rise = -1; last_fall = -1; hold1 = -1; mosi_hi = 1'b0; prev_sclk = 1'b0;
    endtask
    task automatic sample(input int e);
        if (spi_sclk && !prev_sclk) begin
            rises++;
            if (first_rise < 0) first_rise = e;
            last_rise = e;
        end
        if (!spi_sclk && prev_sclk) last_fall = e;
        prev_sclk = spi_sclk;
        if (host.busy) busy_n++;
        if (spi_mosi) mosi_hi = 1'b1;
        if (host.done) begin
            dones++;
            if (done_edge < 0) begin done_edge = e; hold1 = e - last_fall; end
        end
        if (spi_cs_n && dones < max_dones) cs_hi++;
    endtask
    task automatic go(input logic [7:0] tx, input logic [7:0] d, input int poke_start, input int poke_div, input int limit);
        int e, t0;
        @(negedge clk);
        host.start = 1'b1; host.tx_data = tx; host.div_val = d; t0 = cyc;
        clr(1);
        do begin
            @(negedge clk);
            e = cyc - t0 - 1;
            sample(e);
            host.start = (e == poke_start - 1);
            if (e == poke_div - 1) host.div_val = 8'd5;
        end while (e < limit);
    endtask
    initial begin
        int e, t0;
        host.start = 1'b0; host.tx_data = '0; host.div_val = '0;
        repeat (2) @(negedge clk);
        check("rst_cs", spi_cs_n, 1);
        check("rst_sclk", spi_sclk, 0);
        check("rst_mosi", spi_mosi, 0);
        check("rst_div_en", div_en, 0);
        check("rst_div_cfg", div_cfg, 0);
        check("rst_busy", host.busy, 0);
        check("rst_done", host.done, 0);
        check("rst_rx", host.rx_data, 0);
        rst_n = 1'b1;
        // loopback 0xA5, D=1
        loop = 1'b1;
        go(8'hA5, 8'd1, -1, -1, 40);
        check("a5_rx", host.rx_data, 8'hA5);
        check("a5_rises", rises, 8);
        check("a5_first_rise", first_rise, 3);
        check("a5_done_edge", done_edge, 35);
        check("a5_busy_cycles", busy_n, 35);
        check("a5_cs_glitch", cs_hi, 0);
        // miso tied high, zero word, D=0
        loop = 1'b0; miso_val = 1'b1;
        go(8'h00, 8'd0, -1, -1, 25);
        check("ff_rx", host.rx_data, 8'hFF);
        check("ff_done_edge", done_edge, 18);
        check("ff_mosi_low", mosi_hi, 0);
        check("ff_rises", rises, 8);
        // second start mid-transfer is ignored
        loop = 1'b1;
        go(8'h5A, 8'd1, 10, -1, 60);
        check("ign_dones", dones, 1);
        check("ign_done_edge", done_edge, 35);
        check("ign_cs_glitch", cs_hi, 0);
        check("ign_busy_cycles", busy_n, 35);
        check("ign_rx", host.rx_data, 8'h5A);
        // div_val change mid-transfer has no effect
        go(8'h81, 8'd1, -1, 4, 40);
        check("div_first_rise", first_rise, 3);
        check("div_last_rise", last_rise, 31);
        check("div_rises", rises, 8);
        check("div_done_edge", done_edge, 35);
        check("div_rx", host.rx_data, 8'h81);
        // reset after third sclk rise
        @(negedge clk);
        host.start = 1'b1; host.tx_data = 8'hFF; host.div_val = 8'd1; t0 = cyc;
        clr(1);
        e = 0;
        while (rises < 3 && e < 100) begin
            @(negedge clk);
            e = cyc - t0 - 1;
            host.start = 1'b0;
            sample(e);
        end
        check("abort_rise_edge", e, 11);
        rst_n = 1'b0;
        #1;
        check("abort_cs", spi_cs_n, 1);
        check("abort_sclk", spi_sclk, 0);
        check("abort_mosi", spi_mosi, 0);
        check("abort_div_en", div_en, 0);
        check("abort_div_cfg", div_cfg, 0);
        check("abort_busy", host.busy, 0);
        check("abort_rx", host.rx_data, 0);
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            if (host.done) dones++;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (host.done) dones++;
        end
        check("abort_no_done", dones, 0);
        go(8'h3C, 8'd1, -1, -1, 40);
        check("after_abort_rx", host.rx_data, 8'h3C);
        check("after_abort_done_edge", done_edge, 35);
        // back-to-back with D=255 and start held high
        @(negedge clk);
        host.start = 1'b1; host.tx_data = 8'hC3; host.div_val = 8'd255; t0 = cyc;
        clr(2);
        e = 0;
        while (dones < 2 && e < 9000) begin
            @(negedge clk);
            e = cyc - t0 - 1;
            sample(e);
            host.start = (dones == 0) || (e == done_edge);
        end
        host.start = 1'b0;
        check("b2b_done1_edge", done_edge, 4353);
        check("b2b_hold1", hold1, 256);
        check("b2b_done2_edge", e, 8707);
        check("b2b_hold2", e - last_fall, 256);
        check("b2b_cs_high", cs_hi, 1);
        check("b2b_rises", rises, 16);
        check("b2b_rx", host.rx_data, 8'hC3);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
